cordic_vectoring: RTL and testbench

- Iterative CORDIC in vectoring mode. Drives y of (x_i, y_i) to zero and returns the angle atan2(y_i, x_i) and the gain-scaled magnitude.
- Counterpart of the rotation-mode cordic. The Jacobi rotation engine uses it to derive rotation angles from matrix elements, and those angles then feed the rotation unit.
- Runs one micro-rotation per clock behind a valid/ready handshake.

---
 rtl/cordic_vectoring.sv | 147 ++++++++++++++
 tb/tb_cordic_vectoring.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: atan2(y,x) and K-scaled magnitude, one micro-rotation per clock.
// Result ITER+1 edges after accept; single transaction in flight, output held until rdy_i.
module cordic_vectoring #(
  parameter int WORD_WIDTH = 20,
  parameter int FRAC_WIDTH = 15,
  parameter int ITER       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [WORD_WIDTH-1:0] x_i,
  input  logic signed [WORD_WIDTH-1:0] y_i,
  input  logic                         vld_i,
  output logic                         rdy_o,
  output logic signed [WORD_WIDTH-1:0] x_o,
  output logic signed [WORD_WIDTH-1:0] y_o,
  output logic signed [WORD_WIDTH-1:0] z_o,
  output logic                         vld_o,
  input  logic                         rdy_i
);

  localparam int IW = WORD_WIDTH + 2;
  localparam int CW = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [WORD_WIDTH-1:0] PI = WORD_WIDTH'(102944);

  localparam logic signed [IW-1:0] SAT_HI = {{3{1'b0}}, {(WORD_WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] SAT_LO = {{3{1'b1}}, {(WORD_WIDTH-1){1'b0}}};

  // Angle table is tabulated for 15 fractional bits and at most 16 steps.
  if (ITER < 8 || ITER > 16 || FRAC_WIDTH != 15) begin : g_param_check
    $error("cordic_vectoring: unsupported ITER/FRAC_WIDTH");
  end

  function automatic logic signed [WORD_WIDTH-1:0] atan_rom(input int idx);
    case (idx)
      0:       return WORD_WIDTH'(25736);
      1:       return WORD_WIDTH'(15193);
      2:       return WORD_WIDTH'(8027);
      3:       return WORD_WIDTH'(4075);
      4:       return WORD_WIDTH'(2045);
      5:       return WORD_WIDTH'(1024);
      6:       return WORD_WIDTH'(512);
      7:       return WORD_WIDTH'(256);
      8:       return WORD_WIDTH'(128);
      9:       return WORD_WIDTH'(64);
      10:      return WORD_WIDTH'(32);
      11:      return WORD_WIDTH'(16);
      12:      return WORD_WIDTH'(8);
      13:      return WORD_WIDTH'(4);
      14:      return WORD_WIDTH'(2);
      15:      return WORD_WIDTH'(1);
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [WORD_WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[WORD_WIDTH-1:0];
    else if (v < SAT_LO) return SAT_LO[WORD_WIDTH-1:0];
    else                 return v[WORD_WIDTH-1:0];
  endfunction

  logic [1:0]                   state;
  logic [CW-1:0]                cnt;
  logic signed [IW-1:0]         xr;
  logic signed [IW-1:0]         yr;
  logic signed [WORD_WIDTH-1:0] zr;
  logic                         zero_vec;

  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] y_ext;
  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;

  assign x_ext = {{2{x_i[WORD_WIDTH-1]}}, x_i};
  assign y_ext = {{2{y_i[WORD_WIDTH-1]}}, y_i};
  assign x_sh  = xr >>> cnt;
  assign y_sh  = yr >>> cnt;

  assign rdy_o = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      xr       <= '0;
      yr       <= '0;
      zr       <= '0;
      zero_vec <= 1'b0;
      x_o      <= '0;
      y_o      <= '0;
      z_o      <= '0;
      vld_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (vld_i) begin
            zero_vec <= (x_i == '0) && (y_i == '0);
            cnt      <= '0;
            state    <= S_ITER;
            // Fold left half-plane into the right so the iterations only cover +-pi/2.
            if (x_i[WORD_WIDTH-1]) begin
              xr <= -x_ext;
              yr <= -y_ext;
              zr <= y_i[WORD_WIDTH-1] ? -PI : PI;
            end else begin
              xr <= x_ext;
              yr <= y_ext;
              zr <= '0;
            end
          end
        end
        S_ITER: begin
          if (cnt == CW'(ITER)) begin
            x_o   <= zero_vec ? '0 : sat(xr);
            y_o   <= zero_vec ? '0 : sat(yr);
            z_o   <= zero_vec ? '0 : zr;
            vld_o <= 1'b1;
            state <= S_DONE;
          end else begin
            if (!yr[IW-1]) begin
              xr <= xr + y_sh;
              yr <= yr - x_sh;
              zr <= zr + atan_rom(int'(cnt));
            end else begin
              xr <= xr - y_sh;
              yr <= yr + x_sh;
              zr <= zr - atan_rom(int'(cnt));
            end
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (rdy_i) begin
            vld_o <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Randomized and directed check of cordic_vectoring against an ideal atan2/hypot model.
// Covers latency, handshake hold, ignored input while busy, saturation, zero vector and mid-run reset.
module tb_cordic_vectoring;

  logic               clk;
  logic               rst;
  logic signed [19:0] x_i;
  logic signed [19:0] y_i;
  logic               vld_i;
  logic               rdy_o;
  logic signed [19:0] x_o;
  logic signed [19:0] y_o;
  logic signed [19:0] z_o;
  logic               vld_o;
  logic               rdy_i;

  int  n_chk  = 0;
  int  n_fail = 0;
  real kgain;

  cordic_vectoring #(
    .WORD_WIDTH(20),
    .FRAC_WIDTH(15),
    .ITER      (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .x_i  (x_i),
    .y_i  (y_i),
    .vld_i(vld_i),
    .rdy_o(rdy_o),
    .x_o  (x_o),
    .y_o  (y_o),
    .z_o  (z_o),
    .vld_o(vld_o),
    .rdy_i(rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
    n_chk++;
    if (got > exp + tol || got < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Ideal result: angle = atan2 in Q15 radians, magnitude = K*|v| clipped to the output range.
  task automatic model(input int xv, input int yv, output longint ez, output longint ex, output longint tx);
    real xf, yf, a, m;
    longint mi;
    xf = real'(xv);
    yf = real'(yv);
    if (xv == 0 && yv == 0) begin
      ez = 0; ex = 0; tx = 0;
    end else begin
      a  = $atan2(yf, xf) * 32768.0;
      ez = longint'($rtoi(a >= 0.0 ? a + 0.5 : a - 0.5));
      m  = $sqrt(xf * xf + yf * yf) * kgain;
      mi = longint'($rtoi(m + 0.5));
      if (mi > 524287 + 8) begin
        ex = 524287; tx = 0;
      end else begin
        ex = (mi > 524287) ? 524287 : mi; tx = 8;
      end
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!rdy_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rdy_wait", longint'(rdy_o), 1);
  endtask

  task automatic run_txn(input int xv, input int yv, input int hold_cyc, input bit poke);
    int lat;
    int changes;
    longint ez, ex, tx;
    logic signed [19:0] xs, ys, zs;
    wait_ready();
    x_i   = 20'(xv);
    y_i   = 20'(yv);
    vld_i = 1'b1;
    rdy_i = (hold_cyc == 0);
    @(posedge clk);
    @(negedge clk);
    vld_i = 1'b0;
    x_i   = 20'($urandom);
    y_i   = 20'($urandom);
    chk("rdy_busy", longint'(rdy_o), 0);
    lat = 0;
    while (!vld_o && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (poke) begin
        vld_i = (lat == 3);
        x_i   = 20'($urandom);
        y_i   = 20'($urandom);
      end
    end
    vld_i = 1'b0;
    chk("latency", lat, 17);
    chk("rdy_done", longint'(rdy_o), 0);
    model(xv, yv, ez, ex, tx);
    chk("z_out", longint'(z_o), ez, (xv == 0 && yv == 0) ? 0 : 4);
    chk("x_out", longint'(x_o), ex, tx);
    chk("y_res", longint'(y_o), 0, (xv == 0 && yv == 0) ? 0 : 128);
    if (hold_cyc > 0) begin
      xs = x_o; ys = y_o; zs = z_o;
      changes = 0;
      repeat (hold_cyc) begin
        @(negedge clk);
        if (vld_o !== 1'b1 || x_o !== xs || y_o !== ys || z_o !== zs || rdy_o !== 1'b0) changes++;
      end
      chk("hold_stable", changes, 0);
      rdy_i = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("vld_clear", longint'(vld_o), 0);
    chk("rdy_back", longint'(rdy_o), 1);
  endtask

  int dx [8] = '{32768, 0, -32768, -32768, 32768, 0, 524287, -524288};
  int dy [8] = '{32768, 32768, 0, -32768, -32768, 0, 524287, 0};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx, ry, tries;
    kgain = 1.0;
    for (int i = 0; i < 16; i++) kgain = kgain * $sqrt(1.0 + $pow(2.0, -2.0 * i));

    rst   = 1'b0;
    vld_i = 1'b0;
    rdy_i = 1'b1;
    x_i   = '0;
    y_i   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", longint'(vld_o), 0);
    chk("rst_rdy", longint'(rdy_o), 1);
    chk("rst_x", longint'(x_o), 0);
    chk("rst_z", longint'(z_o), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) run_txn(dx[k], dy[k], 0, 1'b0);

    run_txn(-20000, 30000, 10, 1'b0);
    run_txn(25000, -12000, 0, 1'b1);

    // Reset in the middle of iteration must drop the transaction and clear held outputs.
    wait_ready();
    x_i = 20'(40000); y_i = 20'(10000); vld_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("mrst_vld", longint'(vld_o), 0);
    chk("mrst_rdy", longint'(rdy_o), 1);
    chk("mrst_x", longint'(x_o), 0);
    chk("mrst_y", longint'(y_o), 0);
    chk("mrst_z", longint'(z_o), 0);
    repeat (20) @(negedge clk);
    chk("mrst_idle", longint'(vld_o), 0);
    run_txn(40000, 10000, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      tries = 0;
      do begin
        rx = int'($urandom_range(393216)) - 196608;
        ry = int'($urandom_range(393216)) - 196608;
        tries++;
      end while ((longint'(rx) * rx + longint'(ry) * ry) < 64'd67108864 && tries < 20);
      if (tries >= 20) begin
        rx = 8192;
        ry = -8192;
      end
      run_txn(rx, ry, (n % 6 == 0) ? 3 : 0, (n % 5 == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
